la_trigger: RTL and testbench

LA_TRIGGER -- requirements
Module: la_trigger

---
 rtl/la_trigger_if.sv | 33 +++
 rtl/la_trigger.sv | 151 +++++++++++++++
 tb/tb_la_trigger.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_trigger_if.sv
`default_nettype none
// ============================================================================
//  Module      : la_trigger_if
//  Description : Control/status bundle between a logic-analyzer trigger
//                block and the agent that configures and arms it.
//                master : drives probe bus, trigger setup, arm/abort.
//                slave  : the trigger block itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface la_trigger_if;
    logic [31:0] SIGNALS;
    logic [31:0] TRIG_MASK;
    logic [31:0] TRIG_VALUE;
    logic [4:0]  POST_COUNT;
    logic        arm;
    logic        abort;
    logic        step_en;
    logic        in_init;
    logic        stop_n;
    logic [4:0]  trig_addr;
    logic [1:0]  STATE;

    modport master (
        output SIGNALS, TRIG_MASK, TRIG_VALUE, POST_COUNT, arm, abort,
        input  step_en, in_init, stop_n, trig_addr, STATE
    );

    modport slave (
        input  SIGNALS, TRIG_MASK, TRIG_VALUE, POST_COUNT, arm, abort,
        output step_en, in_init, stop_n, trig_addr, STATE
    );
endinterface : la_trigger_if
`default_nettype wire

// File: rtl/la_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : la_trigger
//  Description : Trigger sequencer for a 32-bit logic analyzer. Arms on
//                request, samples until the masked compare fires, runs a
//                programmable number of post-trigger samples, then reports
//                capture stopped together with the trigger sample index.
//                Optional macro LA_TRIG_EDGE_EN selects rising-edge trigger
//                on the compare result instead of level trigger.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_trigger (
    input  logic        CLK,
    input  logic        RST_N,
    la_trigger_if.slave bus
);

    // State codes are visible on the STATE output, so the encoding is fixed.
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PRE  = 2'd1;
    localparam logic [1:0] c_ST_POST = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [4:0] r_scnt;        // sample index, wraps modulo 32
    logic [4:0] r_pcnt;        // post-trigger samples remaining
    logic [4:0] r_trig_addr;
    logic       w_match;
    logic       w_fire;
    logic       w_start;       // arm/re-arm accepted this cycle
    logic       w_trig;        // trigger accepted this cycle
    logic       w_sampling;

    // Live masked compare; a zero mask matches unconditionally.
    assign w_match = (((bus.SIGNALS ^ bus.TRIG_VALUE) & bus.TRIG_MASK) == 32'd0);

`ifdef LA_TRIG_EDGE_EN
    logic r_prev_match;

    // Previous compare result; forced high at arm so a condition that is
    // already true when the capture starts does not count as an edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prev_match <= 1'b0;
        end else if (w_start) begin
            r_prev_match <= 1'b1;
        end else if (r_state == c_ST_PRE) begin
            r_prev_match <= w_match;
        end
    end

    assign w_fire = w_match & ~r_prev_match;
`else
    assign w_fire = w_match;
`endif

    assign w_sampling = (r_state == c_ST_PRE) || (r_state == c_ST_POST);

    // Next-state decode; abort has priority over arm in every state.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_trig      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!bus.abort && bus.arm) begin
                    w_state_nxt = c_ST_PRE;
                    w_start     = 1'b1;
                end
            end
            c_ST_PRE: begin
                if (bus.abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_fire) begin
                    w_trig      = 1'b1;
                    w_state_nxt = (r_pcnt == 5'd0) ? c_ST_DONE : c_ST_POST;
                end
            end
            c_ST_POST: begin
                if (bus.abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_pcnt == 5'd1) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (bus.abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (bus.arm) begin
                    w_state_nxt = c_ST_PRE;
                    w_start     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample counter: cleared at arm, advances on every sampled cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_scnt <= 5'd0;
        end else if (w_start) begin
            r_scnt <= 5'd0;
        end else if (w_sampling) begin
            r_scnt <= r_scnt + 5'd1;
        end
    end

    // Post-trigger length is captured at arm and held through PRE, so the
    // value in r_pcnt at trigger time is already the load value for POST.
    // Later POST_COUNT changes cannot affect the running capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pcnt <= 5'd0;
        end else if (w_start) begin
            r_pcnt <= bus.POST_COUNT;
        end else if ((r_state == c_ST_POST) && !bus.abort) begin
            r_pcnt <= r_pcnt - 5'd1;
        end
    end

    // Trigger index: updated only when a trigger is accepted, survives abort.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_trig_addr <= 5'd0;
        end else if (w_trig) begin
            r_trig_addr <= r_scnt;
        end
    end

    // Outputs are pure decodes of registered state.
    assign bus.STATE     = r_state;
    assign bus.step_en   = w_sampling;
    assign bus.in_init   = (r_state == c_ST_IDLE);
    assign bus.stop_n    = (r_state != c_ST_DONE);
    assign bus.trig_addr = r_trig_addr;

endmodule : la_trigger
`default_nettype wire

// File: tb/tb_la_trigger.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_trigger
//  Description : Self-checking bench for la_trigger. A capture-level model
//                (phase, absolute sample count, post samples seen) predicts
//                every output each cycle; directed scenarios add literal
//                expectations for the key sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_trigger;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    always #5 CLK = ~CLK;

    la_trigger_if bus ();

    la_trigger dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Model: phase 0=IDLE 1=PRE 2=POST 3=DONE
    int m_phase     = 0;
    int m_samples   = 0;
    int m_post_len  = 0;
    int m_post_seen = 0;
    int m_trig      = 0;
    bit m_prev      = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_samples   = 0;
        m_post_len  = 0;
        m_post_seen = 0;
        m_trig      = 0;
        m_prev      = 1'b0;
    endtask

    task automatic model_start();
        m_phase    = 1;
        m_samples  = 0;
        m_post_len = int'(bus.POST_COUNT);
        m_prev     = 1'b1;
    endtask

    task automatic model_step();
        bit match;
        bit fire;
        match = (((bus.SIGNALS ^ bus.TRIG_VALUE) & bus.TRIG_MASK) == 32'd0);
`ifdef LA_TRIG_EDGE_EN
        fire = match && !m_prev;
`else
        fire = match;
`endif
        case (m_phase)
            0: if (!bus.abort && bus.arm) model_start();
            1: begin
                if (bus.abort) begin
                    m_phase = 0;
                end else if (fire) begin
                    m_trig      = m_samples % 32;
                    m_post_seen = 0;
                    m_phase     = (m_post_len == 0) ? 3 : 2;
                end
                m_prev = match;
                m_samples++;
            end
            2: begin
                if (bus.abort) begin
                    m_phase = 0;
                end else begin
                    m_post_seen++;
                    if (m_post_seen == m_post_len) m_phase = 3;
                end
                m_samples++;
            end
            default: begin
                if (bus.abort) m_phase = 0;
                else if (bus.arm) model_start();
            end
        endcase
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) model_reset();
            else        model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_state",   32'(bus.STATE),     32'(m_phase));
            chk("m_step_en", 32'(bus.step_en),   32'((m_phase == 1) || (m_phase == 2)));
            chk("m_in_init", 32'(bus.in_init),   32'(m_phase == 0));
            chk("m_stop_n",  32'(bus.stop_n),    32'(m_phase != 3));
            chk("m_taddr",   32'(bus.trig_addr), 32'(m_trig));
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_arm();
        bus.arm = 1'b1;
        @(negedge CLK);
        bus.arm = 1'b0;
    endtask

    int cnt;
    int exp_seq [5];

    initial begin
        bus.SIGNALS    = 32'd0;
        bus.TRIG_MASK  = 32'd0;
        bus.TRIG_VALUE = 32'd0;
        bus.POST_COUNT = 5'd0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;

        // Reset state
        run(3);
        chk("rst_state",   32'(bus.STATE),     32'd0);
        chk("rst_step_en", 32'(bus.step_en),   32'd0);
        chk("rst_in_init", 32'(bus.in_init),   32'd1);
        chk("rst_stop_n",  32'(bus.stop_n),    32'd1);
        chk("rst_taddr",   32'(bus.trig_addr), 32'd0);
        RST_N  = 1'b1;
        cmp_en = 1'b1;
        run(2);
        chk("idle_hold", 32'(bus.STATE), 32'd0);

        // Abort in IDLE does nothing
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;
        chk("abort_idle", 32'(bus.STATE), 32'd0);

        // Basic capture with signal already matching at arm
        bus.TRIG_MASK  = 32'h1;
        bus.TRIG_VALUE = 32'h1;
        bus.SIGNALS    = 32'h1;
        bus.POST_COUNT = 5'd3;
        pulse_arm();
`ifndef LA_TRIG_EDGE_EN
        exp_seq = '{1, 2, 2, 2, 3};
        for (int i = 0; i < 5; i++) begin
            chk("a_seq", 32'(bus.STATE), 32'(exp_seq[i]));
            run(1);
        end
        chk("a_stop_n", 32'(bus.stop_n),    32'd0);
        chk("a_taddr",  32'(bus.trig_addr), 32'd0);
`else
        run(5);
        chk("e_no_fire", 32'(bus.STATE), 32'd1);
        bus.SIGNALS = 32'h0;
        run(1);
        chk("e_still_pre", 32'(bus.STATE), 32'd1);
        bus.SIGNALS = 32'h1;
        run(1);
        chk("e_fire_state", 32'(bus.STATE),     32'd2);
        chk("e_fire_taddr", 32'(bus.trig_addr), 32'd6);
        run(3);
        chk("e_stop_n", 32'(bus.stop_n), 32'd0);
`endif

        // POST_COUNT=0: match on 5th PRE cycle goes straight to DONE (re-arm from DONE)
        bus.TRIG_MASK  = 32'hFF;
        bus.TRIG_VALUE = 32'hA5;
        bus.SIGNALS    = 32'h5A;
        bus.POST_COUNT = 5'd0;
        pulse_arm();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.step_en) cnt++;
            if (i == 4) bus.SIGNALS = 32'h1A5;
            run(1);
        end
        chk("b_step_cycles", 32'(cnt),           32'd5);
        chk("b_state",       32'(bus.STATE),     32'd3);
        chk("b_taddr",       32'(bus.trig_addr), 32'd4);
        chk("b_stop_n",      32'(bus.stop_n),    32'd0);

        // Long PRE with counter wrap; mid-capture arm/POST_COUNT/mask changes ignored
        bus.SIGNALS    = 32'h0;
        bus.POST_COUNT = 5'd2;
        pulse_arm();
        cnt = 0;
        for (int i = 0; i < 48; i++) begin
            if (bus.step_en) cnt++;
            if (i == 5)  bus.POST_COUNT = 5'd7;
            if (i == 10) bus.arm = 1'b1;
            if (i == 11) bus.arm = 1'b0;
            if (i == 40) bus.SIGNALS = 32'hA5;
            if (i == 41) bus.TRIG_MASK = 32'h0;
            run(1);
        end
        chk("c_step_cycles", 32'(cnt),           32'd43);
        chk("c_taddr",       32'(bus.trig_addr), 32'd8);
        chk("c_state",       32'(bus.STATE),     32'd3);

        // Abort during POST; trig_addr survives abort
        bus.TRIG_MASK  = 32'hFF;
        bus.SIGNALS    = 32'h0;
        bus.POST_COUNT = 5'd5;
        pulse_arm();
        run(1);
        bus.SIGNALS = 32'hA5;
        run(1);
        chk("d_post", 32'(bus.STATE), 32'd2);
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;
        chk("d_state",   32'(bus.STATE),     32'd0);
        chk("d_in_init", 32'(bus.in_init),   32'd1);
        chk("d_stop_n",  32'(bus.stop_n),    32'd1);
        chk("d_taddr",   32'(bus.trig_addr), 32'd1);

        // Arm and abort together in DONE: abort wins
        bus.SIGNALS    = 32'h0;
        bus.POST_COUNT = 5'd1;
        pulse_arm();
        run(1);
        bus.SIGNALS = 32'hA5;
        run(2);
        chk("d2_done", 32'(bus.STATE), 32'd3);
        bus.arm   = 1'b1;
        bus.abort = 1'b1;
        run(1);
        bus.arm   = 1'b0;
        bus.abort = 1'b0;
        chk("d2_state", 32'(bus.STATE), 32'd0);

        // Zero mask matches every cycle
        bus.TRIG_MASK  = 32'h0;
        bus.SIGNALS    = 32'hDEADBEEF;
        bus.POST_COUNT = 5'd2;
        pulse_arm();
        run(6);
`ifndef LA_TRIG_EDGE_EN
        chk("z_state", 32'(bus.STATE),     32'd3);
        chk("z_taddr", 32'(bus.trig_addr), 32'd0);
`else
        chk("z_state", 32'(bus.STATE), 32'd1);
`endif
        bus.abort = 1'b1;
        run(1);
        bus.abort = 1'b0;

        // Asynchronous reset in the middle of POST
        bus.TRIG_MASK  = 32'hFF;
        bus.TRIG_VALUE = 32'hA5;
        bus.SIGNALS    = 32'h0;
        bus.POST_COUNT = 5'd10;
        pulse_arm();
        run(1);
        bus.SIGNALS = 32'hA5;
        run(2);
        chk("g_post",  32'(bus.STATE),     32'd2);
        chk("g_taddr", 32'(bus.trig_addr), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("g_rst_state",   32'(bus.STATE),     32'd0);
        chk("g_rst_step_en", 32'(bus.step_en),   32'd0);
        chk("g_rst_in_init", 32'(bus.in_init),   32'd1);
        chk("g_rst_stop_n",  32'(bus.stop_n),    32'd1);
        chk("g_rst_taddr",   32'(bus.trig_addr), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        run(3);
        chk("g_after_state",  32'(bus.STATE),  32'd0);
        chk("g_after_stop_n", 32'(bus.stop_n), 32'd1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_la_trigger
`default_nettype wire
